// File: rtl/soi_obs_pkg.sv
// Shared types and default widths for the SOI capture scheduler.
package soi_obs_pkg;

    localparam int NUM_SOI_DEF = 4;
    localparam int DATA_W_DEF  = 8;
    localparam int DEPTH_DEF   = 8;
    localparam int TS_W_DEF    = 16;

    localparam int CH_W  = $clog2(NUM_SOI_DEF);
    localparam int REC_W = TS_W_DEF + CH_W + DATA_W_DEF;
    localparam int CNT_W = $clog2(DEPTH_DEF) + 1;

    // One change record as it sits in the FIFO and appears on rd_data.
    typedef struct packed {
        logic [TS_W_DEF-1:0]   ts;
        logic [CH_W-1:0]       ch_id;
        logic [DATA_W_DEF-1:0] value;
    } soi_rec_t;

    typedef enum logic [1:0] {
        DISABLED = 2'd0,
        PRIME    = 2'd1,
        RUN      = 2'd2
    } soi_state_t;

endpackage

// File: rtl/soi_capture_sched_if.sv
// Host-side read port of the SOI capture scheduler.
//
// Handshake: rd_valid is high whenever the FIFO head holds a record and
// rd_data shows that head (show-ahead). The record is consumed on the rising
// clock edge where rd_req && rd_valid; rd_req while rd_valid is low does
// nothing. clr_ovf is a one-cycle request to clear the sticky overflow flag.
interface soi_capture_sched_if #(
    parameter int REC_W = soi_obs_pkg::REC_W,
    parameter int CNT_W = soi_obs_pkg::CNT_W
);
    logic             rd_req;
    logic             clr_ovf;
    logic             rd_valid;
    logic [REC_W-1:0] rd_data;
    logic [CNT_W-1:0] count;
    logic             overflow;

    modport master (output rd_req, clr_ovf, input rd_valid, rd_data, count, overflow);
    modport slave  (input rd_req, clr_ovf, output rd_valid, rd_data, count, overflow);
endinterface

// File: rtl/soi_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module soi_rr_arbiter #(
    parameter int NUM_SOI = 4,
    parameter int ID_W    = $clog2(NUM_SOI)
) (
    input  logic [NUM_SOI-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    input  logic               en,
    output logic [NUM_SOI-1:0] grant,
    output logic [ID_W-1:0]    grant_idx,
    output logic               valid
);

    logic [ID_W-1:0] idx;

    // Scan channels starting at ptr, wrapping, and keep the first hit.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        valid     = 1'b0;
        idx       = '0;
        if (en) begin
            for (int k = 0; k < NUM_SOI; k++) begin
                idx = ID_W'((int'(ptr) + k) % NUM_SOI);
                if (!valid && req[idx]) begin
                    valid      = 1'b1;
                    grant[idx] = 1'b1;
                    grant_idx  = idx;
                end
            end
        end
    end

endmodule

// File: rtl/soi_capture_sched.sv
// SOI capture scheduler: detects probe value changes, arbitrates pending
// channels round-robin and stores timestamped records in a show-ahead FIFO.
module soi_capture_sched
    import soi_obs_pkg::*;
#(
    parameter int NUM_SOI = NUM_SOI_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int TS_W    = TS_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic [NUM_SOI-1:0]        soi_mask,
    input  logic [NUM_SOI*DATA_W-1:0] soi_val,
    soi_capture_sched_if.slave        host,
    output soi_state_t                dbg_state
);

    localparam int ID_W = $clog2(NUM_SOI);
    localparam int AW   = $clog2(DEPTH);
    localparam int RW   = TS_W + ID_W + DATA_W;

    soi_state_t        state_q, state_d;
    logic [TS_W-1:0]   ts_q;
    logic [DATA_W-1:0] last_q [NUM_SOI];
    logic [DATA_W-1:0] val_q  [NUM_SOI];
    logic [TS_W-1:0]   tsl_q  [NUM_SOI];
    logic [NUM_SOI-1:0] pend_q, chg, gnt;
    logic [ID_W-1:0]   rr_q, gnt_idx;
    logic              gnt_vld, arb_en;
    logic [RW-1:0]     mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       cnt_q;
    logic              full, empty, pop, push, lost, ovf_q;

    assign empty  = (cnt_q == '0);
    assign full   = (cnt_q == (AW+1)'(DEPTH));
    assign pop    = host.rd_req && !empty;
    // Nothing is granted while disabling; a full FIFO accepts a push only alongside a pop.
    assign arb_en = enable && (!full || pop);
    assign push   = gnt_vld;
    // A change is lost when it lands on a pending channel that is not draining this cycle.
    assign lost   = |(chg & pend_q & ~gnt);

    // Free-running timestamp, independent of the capture state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ts_q <= '0;
        else        ts_q <= ts_q + 1'b1;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= DISABLED;
        else        state_q <= state_d;
    end

    // Next state: PRIME lasts exactly one cycle; dropping enable always wins.
    always_comb begin
        state_d = state_q;
        case (state_q)
            DISABLED: if (enable) state_d = PRIME;
            PRIME:    state_d = RUN;
            default:  state_d = RUN;
        endcase
        if (!enable) state_d = DISABLED;
    end

    // Change detect, only while running with the channel unmasked.
    always_comb begin
        chg = '0;
        for (int i = 0; i < NUM_SOI; i++) begin
            chg[i] = (state_q == RUN) && enable && soi_mask[i] &&
                     (soi_val[i*DATA_W +: DATA_W] != last_q[i]);
        end
    end

    soi_rr_arbiter #(.NUM_SOI(NUM_SOI), .ID_W(ID_W)) u_arb (
        .req       (pend_q),
        .ptr       (rr_q),
        .en        (arb_en),
        .grant     (gnt),
        .grant_idx (gnt_idx),
        .valid     (gnt_vld)
    );

    // Per-channel last value, pending flag and latched record fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
            for (int i = 0; i < NUM_SOI; i++) begin
                last_q[i] <= '0;
                val_q[i]  <= '0;
                tsl_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SOI; i++) begin
                if (state_q != DISABLED) last_q[i] <= soi_val[i*DATA_W +: DATA_W];
                if (!enable) begin
                    pend_q[i] <= 1'b0;
                end else if (chg[i]) begin
                    pend_q[i] <= 1'b1;
                    val_q[i]  <= soi_val[i*DATA_W +: DATA_W];
                    tsl_q[i]  <= ts_q;
                end else if (gnt[i]) begin
                    pend_q[i] <= 1'b0;
                end
            end
        end
    end

    // Round-robin pointer moves just past the last granted channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       rr_q <= '0;
        else if (gnt_vld) rr_q <= (gnt_idx == ID_W'(NUM_SOI - 1)) ? '0 : gnt_idx + 1'b1;
    end

    // Sticky overflow; a new loss beats a clear in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            ovf_q <= 1'b0;
        else if (lost)         ovf_q <= 1'b1;
        else if (host.clr_ovf) ovf_q <= 1'b0;
    end

    // FIFO pointers and exact occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      cnt_q <= cnt_q + 1'b1;
            else if (pop && !push) cnt_q <= cnt_q - 1'b1;
        end
    end

    // FIFO storage; when full, the slot written is the one being popped.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {tsl_q[gnt_idx], gnt_idx, val_q[gnt_idx]};
    end

    assign host.rd_valid = !empty;
    assign host.rd_data  = empty ? '0 : mem[rd_ptr];
    assign host.count    = cnt_q;
    assign host.overflow = ovf_q;
    assign dbg_state     = state_q;

endmodule
